cordic_prescale_pipe: RTL and testbench

//  Parametrised, flow-controlled CORDIC prescale stage. Sits between primitive setup and the CORDIC rotation pipeline.

---
 rtl/cordic_prescale_pipe.sv | 117 +++++++++++
 tb/tb_cordic_prescale_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_prescale_pipe.sv
// cordic_prescale_pipe: two-stage valid/ready CORDIC start-vector prescale with K^-1 gain compensation.
// Defining CORDIC_PRESCALE_SAT_EN clamps the output to the symmetric OUT_W range and raises out_sat.
module cordic_prescale_pipe #(
    parameter int SIZE_W     = 7,
    parameter int FRAC_W     = 8,
    parameter int OUT_W      = 19,
    parameter int ANG_W      = 9,
    parameter int GAIN       = 155,
    parameter int GAIN_SHIFT = 8,
    parameter int SB_W       = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE_W-1:0] in_size,
    input  logic [ANG_W-1:0]  in_angle,
    input  logic [SB_W-1:0]   in_sb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  cord_pos,
    output logic [OUT_W-1:0]  cord_neg,
    output logic              enable_cordic,
    output logic [ANG_W-1:0]  out_angle,
    output logic [SB_W-1:0]   out_sb,
    output logic              out_sat
);
    localparam int PW = SIZE_W + FRAC_W + $clog2(GAIN + 1) + 1;
    // Extended width keeps the signed value and its negation exact before truncation.
    localparam int EW = (PW > OUT_W) ? PW : OUT_W + 1;

    logic              s1_valid, s2_valid;
    logic              adv1, adv2;
    logic [PW-1:0]     s1_prod;
    logic [ANG_W-1:0]  s1_angle;
    logic [SB_W-1:0]   s1_sb;
    logic              s1_enable;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    logic              in_enable;
    logic [PW-1:0]     base, prod_next;

    // Any bit below the quarter-turn position means the angle needs real rotation.
    assign in_enable = |in_angle[ANG_W-3:0];
    assign base      = PW'(in_size) << FRAC_W;
    assign prod_next = in_enable ? base * PW'(GAIN) : base << GAIN_SHIFT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_angle  <= '0;
            s1_sb     <= '0;
            s1_enable <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_prod   <= prod_next;
                s1_angle  <= in_angle;
                s1_sb     <= in_sb;
                s1_enable <= in_enable;
            end
        end
    end

    logic signed [EW-1:0] prod_ext, val, clamped;
    logic                 sat;

    assign prod_ext = EW'(s1_prod);
    assign val      = prod_ext >>> GAIN_SHIFT;

`ifdef CORDIC_PRESCALE_SAT_EN
    localparam logic signed [EW-1:0] VMAX = EW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);

    always_comb begin
        clamped = val;
        sat     = 1'b0;
        if (val > VMAX) begin
            clamped = VMAX;
            sat     = 1'b1;
        end else if (val < -VMAX) begin
            clamped = -VMAX;
            sat     = 1'b1;
        end
    end
`else
    assign clamped = val;
    assign sat     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid      <= 1'b0;
            cord_pos      <= '0;
            cord_neg      <= '0;
            enable_cordic <= 1'b0;
            out_angle     <= '0;
            out_sb        <= '0;
            out_sat       <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                cord_pos      <= OUT_W'(clamped);
                cord_neg      <= OUT_W'(-clamped);
                enable_cordic <= s1_enable;
                out_angle     <= s1_angle;
                out_sb        <= s1_sb;
                out_sat       <= sat;
            end
        end
    end

endmodule

// File: tb/tb_cordic_prescale_pipe.sv
// Bench for cordic_prescale_pipe: directed cases plus random valid/ready traffic against a scoreboard model.
// A second instance with OUT_W=15 shares the stimulus to exercise wrap/saturation (CORDIC_PRESCALE_SAT_EN aware).
module tb_cordic_prescale_pipe;
    localparam int SIZE_W     = 7;
    localparam int FRAC_W     = 8;
    localparam int OUT_W      = 19;
    localparam int OUT_W15    = 15;
    localparam int ANG_W      = 9;
    localparam int GAIN       = 155;
    localparam int GAIN_SHIFT = 8;
    localparam int SB_W       = 48;
    localparam int QTR        = 1 << (ANG_W - 2);

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid, out_ready;
    logic [SIZE_W-1:0]  in_size;
    logic [ANG_W-1:0]   in_angle;
    logic [SB_W-1:0]    in_sb;
    logic               in_ready, out_valid, enable_cordic, out_sat;
    logic [OUT_W-1:0]   cord_pos, cord_neg;
    logic [ANG_W-1:0]   out_angle;
    logic [SB_W-1:0]    out_sb;
    logic               rdy15, vld15, en15, sat15;
    logic [OUT_W15-1:0] pos15, neg15;
    logic [ANG_W-1:0]   ang15;
    logic [SB_W-1:0]    sb15;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int               size;
        logic [ANG_W-1:0] angle;
        logic [SB_W-1:0]  sb;
        int               acc;
    } item_t;
    item_t q[$];

    cordic_prescale_pipe #(
        .SIZE_W(SIZE_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W), .ANG_W(ANG_W),
        .GAIN(GAIN), .GAIN_SHIFT(GAIN_SHIFT), .SB_W(SB_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_size(in_size), .in_angle(in_angle), .in_sb(in_sb),
        .out_valid(out_valid), .out_ready(out_ready),
        .cord_pos(cord_pos), .cord_neg(cord_neg), .enable_cordic(enable_cordic),
        .out_angle(out_angle), .out_sb(out_sb), .out_sat(out_sat)
    );

    cordic_prescale_pipe #(
        .SIZE_W(SIZE_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W15), .ANG_W(ANG_W),
        .GAIN(GAIN), .GAIN_SHIFT(GAIN_SHIFT), .SB_W(SB_W)
    ) dut15 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy15),
        .in_size(in_size), .in_angle(in_angle), .in_sb(in_sb),
        .out_valid(vld15), .out_ready(out_ready),
        .cord_pos(pos15), .cord_neg(neg15), .enable_cordic(en15),
        .out_angle(ang15), .out_sb(sb15), .out_sat(sat15)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Start value as real arithmetic: size in fixed point, scaled by GAIN/2^GAIN_SHIFT when rotating.
    function automatic longint ref_val(input int size, input bit en);
        longint b;
        b = longint'(size) * (64'sd1 << FRAC_W);
        if (en) return (b * GAIN) / (64'sd1 << GAIN_SHIFT);
        return b;
    endfunction

    function automatic longint fit(input longint v, input int w);
        longint m, r;
        m = (64'sd1 << (w - 1)) - 1;
`ifdef CORDIC_PRESCALE_SAT_EN
        r = (v > m) ? m : ((v < -m) ? -m : v);
`else
        r = v & ((64'sd1 << w) - 1);
        if (r > m) r = r - (64'sd1 << w);
`endif
        return r;
    endfunction

    function automatic longint fit_sat(input longint v, input int w);
`ifdef CORDIC_PRESCALE_SAT_EN
        return ((v > (64'sd1 << (w - 1)) - 1) || (v < 1 - (64'sd1 << (w - 1)))) ? 1 : 0;
`else
        return (v != v + w) ? 0 : 1;
`endif
    endfunction

    // Scoreboard: items in flight == accepted but not yet taken; oldest is visible two edges after accept.
    always @(negedge clk) begin
        bit     exp_ov, en;
        item_t  it;
        longint v;
        if (!reset) begin
            exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
            chk("in_ready", longint'(in_ready), longint'(q.size() < 2 || out_ready));
            chk("in_ready15", longint'(rdy15), longint'(q.size() < 2 || out_ready));
            chk("out_valid", longint'(out_valid), longint'(exp_ov));
            chk("out_valid15", longint'(vld15), longint'(exp_ov));
            if (out_valid && q.size() > 0) begin
                it = q[0];
                en = (int'($signed(it.angle)) % QTR) != 0;
                v  = ref_val(it.size, en);
                chk("pos", $signed(cord_pos), fit(v, OUT_W));
                chk("neg", $signed(cord_neg), fit(-v, OUT_W));
                chk("enable", longint'(enable_cordic), longint'(en));
                chk("angle", longint'(out_angle), longint'(it.angle));
                chk("sb", longint'(out_sb), longint'(it.sb));
                chk("sat", longint'(out_sat), fit_sat(v, OUT_W));
                chk("pos15", $signed(pos15), fit(v, OUT_W15));
                chk("neg15", $signed(neg15), fit(-v, OUT_W15));
                chk("sat15", longint'(sat15), fit_sat(v, OUT_W15));
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                it.size  = int'(in_size);
                it.angle = in_angle;
                it.sb    = in_sb;
                it.acc   = cyc;
                q.push_back(it);
            end
        end
    end

    // Holds one item on the input until accepted; returns 1 ns after the accepting edge.
    task automatic push(input int size, input int angle, input logic [SB_W-1:0] sb);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_size  = SIZE_W'(size);
        in_angle = ANG_W'(angle);
        in_sb    = sb;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        chk("push_accept", longint'(ok), 1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_size = '0; in_angle = '0; in_sb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_pos", longint'(cord_pos), 0);
        chk("rst_neg", longint'(cord_neg), 0);
        chk("rst_sb", longint'(out_sb), 0);
        chk("rst_en", longint'(enable_cordic), 0);
        reset = 1'b0;
        #1;
        chk("rst_ready", longint'(in_ready), 1);

        // single rotated item
        out_ready = 1'b1;
        push(100, 5, 48'hABCD_1234_5678);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("t1_valid", longint'(out_valid), 1);
        chk("t1_pos", $signed(cord_pos), 15500);
        chk("t1_neg", $signed(cord_neg), -15500);
        chk("t1_en", longint'(enable_cordic), 1);
        chk("t1_sb", longint'(out_sb), 64'hABCD_1234_5678);

        // quarter-turn angles skip gain compensation
        push(100, 0, 48'h1);
        push(100, -128, 48'h2);
        in_valid = 1'b0;
        chk("t2a_pos", $signed(cord_pos), 25600);
        chk("t2a_en", longint'(enable_cordic), 0);
        @(posedge clk); #1;
        chk("t2b_pos", $signed(cord_pos), 25600);
        chk("t2b_neg", $signed(cord_neg), -25600);
        chk("t2b_en", longint'(enable_cordic), 0);
        chk("t2b_angle", longint'(out_angle), 64'h180);

        // OUT_W=15 instance overflows at size 127
        push(127, 5, 48'h3);
        in_valid = 1'b0;
        @(posedge clk); #1;
`ifdef CORDIC_PRESCALE_SAT_EN
        chk("t5_pos", $signed(pos15), 16383);
        chk("t5_neg", $signed(neg15), -16383);
        chk("t5_sat", longint'(sat15), 1);
`else
        chk("t5_pos", $signed(pos15), -13083);
        chk("t5_neg", $signed(neg15), 13083);
        chk("t5_sat", longint'(sat15), 0);
`endif

        // stall with three offered items, release after 5 cycles
        out_ready = 1'b0;
        fork
            begin
                push(10, 3, 48'h10);
                push(20, 130, 48'h20);
                push(30, 128, 48'h30);
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join

        // back-to-back stream
        for (int i = 0; i < 10; i++) push(i * 11, i * 37, SB_W'(i + 64'h100));
        in_valid = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_size   = SIZE_W'($urandom);
            in_angle  = ($urandom_range(0, 3) == 0) ? ANG_W'($urandom_range(0, 3) * QTR)
                                                    : ANG_W'($urandom);
            in_sb     = {16'($urandom), $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("drain", longint'(q.size()), 0);

        // reset with two items buffered
        out_ready = 1'b0;
        push(10, 5, 48'h77);
        push(20, 0, 48'h88);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", longint'(out_valid), 0);
        chk("t6_pos", longint'(cord_pos), 0);
        chk("t6_neg", longint'(cord_neg), 0);
        chk("t6_sb", longint'(out_sb), 0);
        chk("t6_valid15", longint'(vld15), 0);
        q.delete();
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        push(50, 7, 48'h99);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_post_valid", longint'(out_valid), 1);
        chk("t6_post_pos", $signed(cord_pos), 7750);
        chk("t6_post_sb", longint'(out_sb), 64'h99);
        repeat (3) @(posedge clk);
        #1;
        chk("final_drain", longint'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
